dram_req_arbiter: RTL

Shares one DRAM memory-controller user port between NREQ cache/refill requesters. Per request, it places the address into the controller address FIFO and any write beats into the write buffer, honouring the registered full flags. It records the requester ID of every outstanding read in an in-order tag FIFO and routes read-buffer beats back to the owning requester. It sits between the cache refill engines and the DRAM controller wrapper; everything it touches is in the CPU clock domain.

---
 rtl/dram_req_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dram_req_arbiter.sv
// Shares one DRAM controller user port among NREQ requesters; reads are tagged in order so beats route back.
// Grants are combinational from req_valid; DRAMARB_FIXED_PRIO_EN selects fixed lowest-index priority.
package dram_req_arbiter_pkg;
  typedef struct packed {
    logic clk;
  } iu_clk_type;
endpackage

module dram_req_arbiter
  import dram_req_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int ADDRW    = 28,
  parameter int DATAW    = 144,
  parameter int WBEATS   = 2,
  parameter int RBEATS   = 2,
  parameter int TAGDEPTH = 8
) (
  input  iu_clk_type              gclk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*ADDRW-1:0]   req_addr,
  input  logic [NREQ*DATAW-1:0]   req_wdata,
  output logic [NREQ-1:0]         req_ack,
  output logic [NREQ-1:0]         req_wbeat,
  input  logic                    af_full,
  input  logic                    wb_full,
  output logic                    af_we,
  output logic [ADDRW-1:0]        af_addr,
  output logic                    af_read,
  output logic                    wb_we,
  output logic [DATAW-1:0]        wb_data,
  input  logic                    rb_empty,
  output logic                    rb_re,
  input  logic [DATAW-1:0]        rb_data,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [DATAW-1:0]        rsp_data,
  output logic                    rsp_last,
  output logic                    tag_full,
  output logic                    err_orphan
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW  = $clog2(TAGDEPTH);
  localparam int WCW = (WBEATS > 1) ? $clog2(WBEATS) : 1;
  localparam int RCW = (RBEATS > 1) ? $clog2(RBEATS) : 1;
  localparam logic [PW:0] TAG_FULL_CNT = (PW+1)'(TAGDEPTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WDATA = 1'b1;

  logic            clk;
  logic [0:0]      state;
  logic [IDW-1:0]  owner;
  logic [WCW-1:0]  wbeat_cnt;
  logic [RCW-1:0]  rbeat_cnt;
  logic [IDW-1:0]  tag_mem [TAGDEPTH];
  logic [PW-1:0]   tag_wptr;
  logic [PW-1:0]   tag_rptr;
  logic [PW:0]     tag_cnt;
  logic            tag_empty;
  logic            tag_push;
  logic            tag_pop;
  logic            rsp_pend;
  logic [NREQ-1:0] elig;
  logic            grant_vld;
  logic [IDW-1:0]  gid;
  logic            grant_wr;
  logic            wd_beat;
  logic [IDW-1:0]  wsel;

  assign clk = gclk.clk;

`ifndef DRAMARB_FIXED_PRIO_EN
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
  logic [IDW-1:0] rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (grant_vld)
      rr_ptr <= (gid == IDW'(NREQ-1)) ? '0 : gid + IDW'(1);
  end
`endif

  assign tag_full  = (tag_cnt == TAG_FULL_CNT);
  assign tag_empty = (tag_cnt == '0);

  // Eligibility uses the registered full flags; nothing is granted in WDATA or while in reset.
  always_comb begin
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] & ~af_full & (req_we[i] ? ~wb_full : ~tag_full);
    if (rst || state != IDLE)
      elig = '0;
  end

  // Scan downwards so the candidate nearest the start position is assigned last and wins.
  always_comb begin
    logic [IDW:0] idx;
    grant_vld = 1'b0;
    gid       = '0;
    idx       = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
`ifdef DRAMARB_FIXED_PRIO_EN
      idx = (IDW+1)'(k);
`else
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= NREQ_W)
        idx = idx - NREQ_W;
`endif
      if (elig[idx[IDW-1:0]]) begin
        grant_vld = 1'b1;
        gid       = idx[IDW-1:0];
      end
    end
  end

  assign grant_wr  = grant_vld & req_we[gid];
  assign wd_beat   = (state == WDATA) & ~wb_full;
  assign wsel      = grant_vld ? gid : owner;

  assign af_we     = grant_vld;
  assign af_addr   = req_addr[gid*ADDRW +: ADDRW];
  assign af_read   = ~req_we[gid];
  assign req_ack   = grant_vld ? (NREQ'(1) << gid) : '0;
  assign wb_we     = grant_wr | wd_beat;
  assign wb_data   = req_wdata[wsel*DATAW +: DATAW];
  assign req_wbeat = wb_we ? (NREQ'(1) << wsel) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      wbeat_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_wr && WBEATS > 1) begin
        state     <= WDATA;
        owner     <= gid;
        wbeat_cnt <= WCW'(1);
      end
    end else if (wd_beat) begin
      if (wbeat_cnt == WCW'(WBEATS-1)) begin
        state     <= IDLE;
        wbeat_cnt <= '0;
      end else begin
        wbeat_cnt <= wbeat_cnt + WCW'(1);
      end
    end
  end

  // Return path: the tag head owns every beat until its last one retires it.
  assign tag_push  = grant_vld & ~req_we[gid];
  assign rb_re     = ~rb_empty & ~tag_empty;
  assign rsp_last  = rsp_pend & ~tag_empty & (rbeat_cnt == RCW'(RBEATS-1));
  assign tag_pop   = rsp_last;
  assign rsp_valid = (rsp_pend & ~tag_empty) ? (NREQ'(1) << tag_mem[tag_rptr]) : '0;
  assign rsp_data  = rb_data;

  always_ff @(posedge clk) begin
    if (tag_push)
      tag_mem[tag_wptr] <= gid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wptr   <= '0;
      tag_rptr   <= '0;
      tag_cnt    <= '0;
      rsp_pend   <= 1'b0;
      rbeat_cnt  <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_pend <= rb_re;
      if (tag_push)
        tag_wptr <= tag_wptr + PW'(1);
      if (tag_pop)
        tag_rptr <= tag_rptr + PW'(1);
      if (tag_push && !tag_pop)
        tag_cnt <= tag_cnt + (PW+1)'(1);
      else if (!tag_push && tag_pop)
        tag_cnt <= tag_cnt - (PW+1)'(1);
      if (rsp_pend && !tag_empty)
        rbeat_cnt <= rsp_last ? '0 : rbeat_cnt + RCW'(1);
      if (!rb_empty && tag_empty)
        err_orphan <= 1'b1;
    end
  end

endmodule
